// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: multi-port memory front-end with round-robin arbitration
// onto a serial packet link. Up to MAX_OUTSTANDING reads may be in flight. The
// link returns read responses in request order, so a tag FIFO of port ids
// routes each response back to the port that issued it.
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   send_flag     one-cycle pulse: send_data/send_length carry a new packet
//   send_data     request packet (write: flag at MSB, then mask/addr/data)
//   send_length   packet length in bytes
//   sendable      transmitter can accept a packet this cycle
//   recv_flag     one-cycle pulse: the presented response was consumed
//   recv_data     response packet; read data sits in [DW-1:0]
//   recv_length   response length (ignored)
//   receivable    a response is available
//   rw_flag_      per port 2 bits: 0 idle, 1 read, 2 write, 3 idle
//   addr_, write_data_, write_mask_   per-port request fields
//   read_data_    per-port last read result
//   busy          per-port slot occupied
//   done          per-port one-cycle completion pulse
module memory_arbiter_rr #(
  parameter int PORT_COUNT      = 2,
  parameter int DATA_WIDTH_BYTE = 4,
  parameter int ADDR_WIDTH_BYTE = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int DW        = 8 * DATA_WIDTH_BYTE,
  localparam int AW        = 8 * ADDR_WIDTH_BYTE,
  localparam int PB        = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
  localparam int SEND_BYTE = DATA_WIDTH_BYTE + ADDR_WIDTH_BYTE + DATA_WIDTH_BYTE / 8 + 1,
  localparam int SW        = SEND_BYTE * 8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  output logic                                 send_flag,
  output logic [SW-1:0]                        send_data,
  output logic [4:0]                           send_length,
  input  logic                                 sendable,
  output logic                                 recv_flag,
  input  logic [SW-1:0]                        recv_data,
  input  logic [4:0]                           recv_length,
  input  logic                                 receivable,
  input  logic [PORT_COUNT*2-1:0]              rw_flag_,
  input  logic [PORT_COUNT*AW-1:0]             addr_,
  input  logic [PORT_COUNT*DW-1:0]             write_data_,
  input  logic [PORT_COUNT*DATA_WIDTH_BYTE-1:0] write_mask_,
  output logic [PORT_COUNT*DW-1:0]             read_data_,
  output logic [PORT_COUNT-1:0]                busy,
  output logic [PORT_COUNT-1:0]                done
);

  localparam int OB = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  // Per-port request slots; busy doubles as the slot-valid bit.
  logic [PORT_COUNT-1:0]      slot_write;
  logic [PORT_COUNT-1:0]      slot_issued;
  logic [AW-1:0]              slot_addr [PORT_COUNT];
  logic [DW-1:0]              slot_data [PORT_COUNT];
  logic [DATA_WIDTH_BYTE-1:0] slot_mask [PORT_COUNT];

  logic [PB-1:0] rr;

  // In-flight read tags, oldest at rd_ptr.
  logic [PB-1:0] tag_mem [MAX_OUTSTANDING];
  logic [OB-1:0] wr_ptr;
  logic [OB-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic                  fifo_full;
  logic                  pop;
  logic [PB-1:0]         head;
  logic [PORT_COUNT-1:0] eligible;
  logic                  gnt_valid;
  logic [PB-1:0]         gnt;
  logic                  issue;
  logic                  push;
  int unsigned           idx;
  logic [SW-1:0]         pkt_write;
  logic [SW-1:0]         pkt_read;
  logic                  unused_inputs;

  assign unused_inputs = ^{recv_length, recv_data[SW-1:DW]};

  assign fifo_full = (count == CW'(MAX_OUTSTANDING));
  assign pop       = receivable && (count != '0);
  assign head      = tag_mem[rd_ptr];
  assign issue     = gnt_valid && sendable;
  assign push      = issue && !slot_write[gnt];

  function automatic logic [OB-1:0] next_ptr(input logic [OB-1:0] p);
    return (p == OB'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned j = 0; j < PORT_COUNT; j++) begin
      eligible[j] = busy[j] && (slot_write[j] || (!slot_issued[j] && !fifo_full));
    end
  end

  // Search starts just after the last granted port, wrapping modulo PORT_COUNT.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= PORT_COUNT; i++) begin
      idx = (32'(rr) + i) % PORT_COUNT;
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt       = PB'(idx);
      end
    end
  end

  always_comb begin
    pkt_write                               = '0;
    pkt_write[SW-1]                         = 1'b1;
    pkt_write[DW+AW +: DATA_WIDTH_BYTE]     = slot_mask[gnt];
    pkt_write[DW +: AW]                     = slot_addr[gnt];
    pkt_write[DW-1:0]                       = slot_data[gnt];
    pkt_read                                = '0;
    pkt_read[AW-1:0]                        = slot_addr[gnt];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      send_flag   <= 1'b0;
      send_data   <= '0;
      send_length <= '0;
      recv_flag   <= 1'b0;
      read_data_  <= '0;
      busy        <= '0;
      done        <= '0;
      slot_write  <= '0;
      slot_issued <= '0;
      for (int unsigned j = 0; j < PORT_COUNT; j++) begin
        slot_addr[j] <= '0;
        slot_data[j] <= '0;
        slot_mask[j] <= '0;
      end
      for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
        tag_mem[k] <= '0;
      end
      rr     <= PB'(PORT_COUNT - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      send_flag <= 1'b0;
      recv_flag <= 1'b0;
      done      <= '0;

      // Capture only looks at pre-edge busy, so a slot freed this edge
      // cannot be refilled until the next one.
      for (int unsigned j = 0; j < PORT_COUNT; j++) begin
        if (!busy[j] && (rw_flag_[2*j +: 2] == 2'd1 || rw_flag_[2*j +: 2] == 2'd2)) begin
          busy[j]        <= 1'b1;
          slot_write[j]  <= rw_flag_[2*j+1];
          slot_issued[j] <= 1'b0;
          slot_addr[j]   <= addr_[j*AW +: AW];
          slot_data[j]   <= write_data_[j*DW +: DW];
          slot_mask[j]   <= write_mask_[j*DATA_WIDTH_BYTE +: DATA_WIDTH_BYTE];
        end
      end

      if (issue) begin
        send_flag <= 1'b1;
        rr        <= gnt;
        if (slot_write[gnt]) begin
          send_data   <= pkt_write;
          send_length <= 5'(SEND_BYTE);
          busy[gnt]   <= 1'b0;
          done[gnt]   <= 1'b1;
        end else begin
          send_data        <= pkt_read;
          send_length      <= 5'(ADDR_WIDTH_BYTE + 1);
          slot_issued[gnt] <= 1'b1;
          tag_mem[wr_ptr]  <= gnt;
          wr_ptr           <= next_ptr(wr_ptr);
        end
      end

      // The issuing port can never be the head: it had no read in flight.
      if (pop) begin
        recv_flag <= 1'b1;
        rd_ptr    <= next_ptr(rd_ptr);
        for (int unsigned j = 0; j < PORT_COUNT; j++) begin
          if (head == PB'(j)) begin
            read_data_[j*DW +: DW] <= recv_data[DW-1:0];
            done[j]                <= 1'b1;
            busy[j]                <= 1'b0;
          end
        end
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      assert (!(push && fifo_full));
    end
  end

endmodule
